matmul3_ctrl: RTL and testbench
===============================

MATMUL3_CTRL -- requirements
Module: matmul3_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand element width.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, MAC result and C element width.
REQ-003 SHALL have parameter DIM, default 3, matrix dimension; only 3 supported.
REQ-004 SHALL have parameter MAC_LAT, default 2, edges from MAC operand presentation to valid mac_result.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, request a 3x3 multiply; sampled only in IDLE.
REQ-008 SHALL have port a_flat, input, 72, matrix A; element (r,c) at bits [8e+7:8e], e=3r+c.
REQ-009 SHALL have port b_flat, input, 72, matrix B, same packing.
REQ-010 SHALL have port mac_row, output, 24, {A[i][0],A[i][1],A[i][2]}, A[i][0] in [23:16].
REQ-011 SHALL have port mac_col, output, 24, {B[0][j],B[1][j],B[2][j]}, B[0][j] in [23:16].
REQ-012 SHALL have port mac_start, output, 1, product-capture enable to the MAC.
REQ-013 SHALL have port mac_result, input, 16, MAC dot-product sum.
REQ-014 SHALL have port c_flat, output, 144, result C; element e at bits [16e+15:16e].
REQ-015 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-016 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start=1 (edge E0); RUN->DRAIN after 9 issues; DRAIN->IDLE after last capture.
REQ-018 At E0 SHALL latch a_flat/b_flat, clear c_flat to 0, set busy=1, issue_idx=0; later input changes SHALL not affect the run.
REQ-019 Issue k (0..8, i=k/3, j=k%3) SHALL drive mac_row/mac_col for the cycle after edge E0+k, row-major order.
REQ-020 mac_start SHALL be high exactly for the cycles after edges E0+1..E0+9, else low.
REQ-021 Element k SHALL be captured from mac_result into c_flat element k at edge E0+k+3.
REQ-022 At edge E0+11 SHALL set done=1 for one cycle, busy=0, state IDLE.
REQ-023 start while busy SHALL be ignored; start high in the done cycle SHALL be accepted (IDLE).
REQ-024 mac_row/mac_col SHALL be 0 outside issue cycles.
REQ-025 Controller SHALL not alter mac_result; sums wrap modulo 2^16.
REQ-026 c_flat SHALL hold its value from done until the next accepted start.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, busy=0, done=0, mac_start=0, mac_row=0, mac_col=0, c_flat=0, counters 0, including mid-run.
REQ-028 After reset release, first rising edge with start=1 SHALL begin a full run normally.

Structure
REQ-029 Shared package matmul3_pkg SHALL hold DATA_WIDTH, ACC_WIDTH, DIM, MAC_LAT and state encodings.
REQ-030 One sub-module matmul3_operand_sel SHALL map issue_idx to mac_row/mac_col; FSM, counters, capture in top.

Verification
REQ-031 A=identity, B elements 1..9 -> c_flat = B, done at E0+11.
REQ-032 A=B=all 1 -> every C element 3; mac_start high 9 consecutive cycles.
REQ-033 A=B=all 255 -> every C element 64003 (195075 mod 65536).
REQ-034 start pulsed at E0+4 with different A -> ignored; result from original A.
REQ-035 reset low at E0+5 -> all outputs 0, IDLE; new start then completes correctly.
REQ-036 start held high through done cycle -> second run begins, done again 11 edges later.

Source files
------------

// File: rtl/matmul3_pkg.sv
// rtl/matmul3_pkg.sv - shared sizing constants and FSM encoding for the 3x3 matrix multiply controller
package matmul3_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 16;
    localparam int DIM        = 3;
    localparam int MAC_LAT    = 2;
    localparam int IDX_W      = $clog2(DIM * DIM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/matmul3_operand_sel.sv
// rtl/matmul3_operand_sel.sv - maps a row-major issue index to the A row and B column presented to the MAC
module matmul3_operand_sel #(
    parameter int DATA_WIDTH = matmul3_pkg::DATA_WIDTH,
    parameter int DIM        = matmul3_pkg::DIM,
    parameter int IDX_W      = matmul3_pkg::IDX_W
) (
    input  logic [DIM*DIM*DATA_WIDTH-1:0] a_i,
    input  logic [DIM*DIM*DATA_WIDTH-1:0] b_i,
    input  logic [IDX_W-1:0]              issue_idx_i,
    input  logic                          issue_en_i,
    output logic [DIM*DATA_WIDTH-1:0]     row_o,
    output logic [DIM*DATA_WIDTH-1:0]     col_o
);

    localparam int SEL_W = $clog2(DIM);

    logic [SEL_W-1:0] row_sel;
    logic [SEL_W-1:0] col_sel;

    always_comb begin
        row_sel = '0;
        col_sel = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if (int'(issue_idx_i) == r * DIM + c) begin
                    row_sel = SEL_W'(r);
                    col_sel = SEL_W'(c);
                end
            end
        end
    end

    // Element 0 of the row/column lands in the most significant slot.
    always_comb begin
        row_o = '0;
        col_o = '0;
        if (issue_en_i) begin
            for (int t = 0; t < DIM; t++) begin
                row_o[(DIM-1-t)*DATA_WIDTH +: DATA_WIDTH] =
                    a_i[(int'(row_sel) * DIM + t) * DATA_WIDTH +: DATA_WIDTH];
                col_o[(DIM-1-t)*DATA_WIDTH +: DATA_WIDTH] =
                    b_i[(t * DIM + int'(col_sel)) * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/matmul3_ctrl.sv
// rtl/matmul3_ctrl.sv - 3x3 matrix multiply controller: streams row/column pairs to an external MAC and gathers C
module matmul3_ctrl #(
    parameter int DATA_WIDTH = matmul3_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = matmul3_pkg::ACC_WIDTH,
    parameter int DIM        = matmul3_pkg::DIM,
    parameter int MAC_LAT    = matmul3_pkg::MAC_LAT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DIM*DIM*DATA_WIDTH-1:0] a_flat,
    input  logic [DIM*DIM*DATA_WIDTH-1:0] b_flat,
    output logic [DIM*DATA_WIDTH-1:0]     mac_row,
    output logic [DIM*DATA_WIDTH-1:0]     mac_col,
    output logic                          mac_start,
    input  logic [ACC_WIDTH-1:0]          mac_result,
    output logic [DIM*DIM*ACC_WIDTH-1:0]  c_flat,
    output logic                          busy,
    output logic                          done
);
    import matmul3_pkg::*;

    localparam int NEL  = DIM * DIM;
    localparam int IW   = $clog2(NEL);
    localparam int PIPE = (MAC_LAT > 1) ? MAC_LAT - 1 : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NEL - 1);

    state_e                        state_q;
    logic [NEL*DATA_WIDTH-1:0]     a_q;
    logic [NEL*DATA_WIDTH-1:0]     b_q;
    logic [NEL*ACC_WIDTH-1:0]      c_q;
    logic [IW-1:0]                 issue_idx_q;
    logic [IW-1:0]                 cap_idx_q;
    logic                          mac_start_q;
    logic [PIPE-1:0]               cap_pipe_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          cap_valid;

    // mac_start trails the operands by one edge; the pipe adds the rest of the MAC latency.
    assign cap_valid = cap_pipe_q[PIPE-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            issue_idx_q <= '0;
            cap_idx_q   <= '0;
            mac_start_q <= 1'b0;
            cap_pipe_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            mac_start_q   <= (state_q == ST_RUN);
            cap_pipe_q[0] <= mac_start_q;
            for (int s = 1; s < PIPE; s++) begin
                cap_pipe_q[s] <= cap_pipe_q[s-1];
            end

            if (cap_valid) begin
                c_q[int'(cap_idx_q)*ACC_WIDTH +: ACC_WIDTH] <= mac_result;
                cap_idx_q <= cap_idx_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q         <= a_flat;
                        b_q         <= b_flat;
                        c_q         <= '0;
                        busy_q      <= 1'b1;
                        issue_idx_q <= '0;
                        cap_idx_q   <= '0;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue_idx_q == LAST_IDX) begin
                        issue_idx_q <= '0;
                        state_q     <= ST_DRAIN;
                    end else begin
                        issue_idx_q <= issue_idx_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cap_valid && cap_idx_q == LAST_IDX) begin
                        cap_idx_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    matmul3_operand_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIM        (DIM),
        .IDX_W      (IW)
    ) u_operand_sel (
        .a_i         (a_q),
        .b_i         (b_q),
        .issue_idx_i (issue_idx_q),
        .issue_en_i  (state_q == ST_RUN),
        .row_o       (mac_row),
        .col_o       (mac_col)
    );

    assign mac_start = mac_start_q;
    assign c_flat    = c_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_matmul3_ctrl.sv
// tb/tb_matmul3_ctrl.sv - self-checking bench for matmul3_ctrl with a two-stage MAC stub
module tb_matmul3_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [71:0]  a_flat = '0;
    logic [71:0]  b_flat = '0;
    logic [23:0]  mac_row;
    logic [23:0]  mac_col;
    logic         mac_start;
    logic [15:0]  mac_result = '0;
    logic [143:0] c_flat;
    logic         busy;
    logic         done;
    logic [15:0]  mac_s1 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    matmul3_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .mac_row    (mac_row),
        .mac_col    (mac_col),
        .mac_start  (mac_start),
        .mac_result (mac_result),
        .c_flat     (c_flat),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [15:0] dot3(input logic [23:0] r, input logic [23:0] c);
        int s;
        s = 0;
        for (int t = 0; t < 3; t++) s += int'(r[8*t +: 8]) * int'(c[8*t +: 8]);
        return 16'(s);
    endfunction

    // External MAC: result valid two edges after the operands are presented.
    always @(posedge clk) begin
        mac_s1     <= dot3(mac_row, mac_col);
        mac_result <= mac_s1;
    end

    function automatic int el(input logic [71:0] m, input int e);
        return int'(m[8*e +: 8]);
    endfunction

    function automatic logic [143:0] ref_matmul(input logic [71:0] a, input logic [71:0] b);
        logic [143:0] c;
        int s;
        c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) s += el(a, 3*i + k) * el(b, 3*k + j);
                c[16*(3*i + j) +: 16] = 16'(s);
            end
        end
        return c;
    endfunction

    function automatic logic [23:0] exp_row(input logic [71:0] m, input int k);
        logic [23:0] r;
        for (int c = 0; c < 3; c++) r[8*(2-c) +: 8] = m[8*(3*(k/3) + c) +: 8];
        return r;
    endfunction

    function automatic logic [23:0] exp_col(input logic [71:0] m, input int k);
        logic [23:0] r;
        for (int t = 0; t < 3; t++) r[8*(2-t) +: 8] = m[8*(3*t + k%3) +: 8];
        return r;
    endfunction

    function automatic logic [71:0] rand72();
        logic [95:0] w;
        w = {$urandom(), $urandom(), $urandom()};
        return w[71:0];
    endfunction

    // Leaves the caller just after the accepting edge E0, start still high.
    task automatic launch(input logic [71:0] a, input logic [71:0] b);
        @(negedge clk);
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp += 6;
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        if (mac_start !== 1'b0) begin n_bad++; $display("FAIL reset_mac_start got %b want 0", mac_start); end
        if (mac_row !== 24'h0)  begin n_bad++; $display("FAIL reset_mac_row got %h want 0", mac_row); end
        if (mac_col !== 24'h0)  begin n_bad++; $display("FAIL reset_mac_col got %h want 0", mac_col); end
        if (c_flat !== 144'h0)  begin n_bad++; $display("FAIL reset_c_flat got %h want 0", c_flat); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_start_busy got %b want 0", busy); end
    endtask

    task automatic test_runs();
        logic [71:0]  a;
        logic [71:0]  b;
        logic [143:0] exp_c;
        logic [23:0]  er;
        logic [23:0]  ec;
        for (int t = 0; t < 7; t++) begin
            a = '0;
            b = '0;
            case (t)
                0: for (int e = 0; e < 9; e++) begin
                       a[8*e +: 8] = (e % 4 == 0) ? 8'd1 : 8'd0;
                       b[8*e +: 8] = 8'(e + 1);
                   end
                1: begin a = {9{8'd1}};   b = {9{8'd1}}; end
                2: begin a = {9{8'd255}}; b = {9{8'd255}}; end
                default: begin a = rand72(); b = rand72(); end
            endcase
            exp_c = ref_matmul(a, b);
            if (t == 0) exp_c = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
            if (t == 1) exp_c = {9{16'd3}};
            if (t == 2) exp_c = {9{16'd64003}};
            launch(a, b);
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                er = (n <= 8) ? exp_row(a, n) : 24'h0;
                ec = (n <= 8) ? exp_col(b, n) : 24'h0;
                n_cmp += 5;
                if (mac_start !== (n >= 1 && n <= 9)) begin n_bad++; $display("FAIL run%0d_mac_start n=%0d got %b", t, n, mac_start); end
                if (mac_row !== er) begin n_bad++; $display("FAIL run%0d_mac_row n=%0d got %h want %h", t, n, mac_row, er); end
                if (mac_col !== ec) begin n_bad++; $display("FAIL run%0d_mac_col n=%0d got %h want %h", t, n, mac_col, ec); end
                if (busy !== (n <= 10)) begin n_bad++; $display("FAIL run%0d_busy n=%0d got %b", t, n, busy); end
                if (done !== (n == 11)) begin n_bad++; $display("FAIL run%0d_done n=%0d got %b", t, n, done); end
                if (n == 0) begin
                    start  = 1'b0;
                    a_flat = rand72();
                    b_flat = rand72();
                end
            end
            n_cmp++;
            if (c_flat !== exp_c) begin n_bad++; $display("FAIL run%0d_c_flat got %h want %h", t, c_flat, exp_c); end
            repeat (3) @(negedge clk);
            n_cmp += 2;
            if (c_flat !== exp_c) begin n_bad++; $display("FAIL run%0d_c_hold got %h want %h", t, c_flat, exp_c); end
            if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL run%0d_idle busy=%b done=%b want 0 0", t, busy, done); end
        end
    endtask

    task automatic test_start_while_busy();
        logic [71:0]  a;
        logic [71:0]  b;
        logic [143:0] exp_c;
        a = rand72();
        b = rand72();
        exp_c = ref_matmul(a, b);
        launch(a, b);
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            n_cmp += 2;
            if (done !== (n == 11)) begin n_bad++; $display("FAIL busy_start_done n=%0d got %b", n, done); end
            if (busy !== (n <= 10)) begin n_bad++; $display("FAIL busy_start_busy n=%0d got %b", n, busy); end
            if (n == 0) start = 1'b0;
            if (n == 3) begin start = 1'b1; a_flat = ~a; end
            if (n == 4) start = 1'b0;
        end
        n_cmp++;
        if (c_flat !== exp_c) begin n_bad++; $display("FAIL busy_start_c_flat got %h want %h", c_flat, exp_c); end
    endtask

    task automatic test_reset_midrun();
        logic [71:0]  a;
        logic [71:0]  b;
        logic [143:0] exp_c;
        launch(rand72(), rand72());
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp += 6;
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
        if (done !== 1'b0)      begin n_bad++; $display("FAIL midreset_done got %b want 0", done); end
        if (mac_start !== 1'b0) begin n_bad++; $display("FAIL midreset_mac_start got %b want 0", mac_start); end
        if (mac_row !== 24'h0)  begin n_bad++; $display("FAIL midreset_mac_row got %h want 0", mac_row); end
        if (mac_col !== 24'h0)  begin n_bad++; $display("FAIL midreset_mac_col got %h want 0", mac_col); end
        if (c_flat !== 144'h0)  begin n_bad++; $display("FAIL midreset_c_flat got %h want 0", c_flat); end
        @(negedge clk);
        reset = 1'b1;
        a = rand72();
        b = rand72();
        exp_c = ref_matmul(a, b);
        launch(a, b);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            n_cmp++;
            if (done !== (n == 11)) begin n_bad++; $display("FAIL postreset_done n=%0d got %b", n, done); end
        end
        n_cmp++;
        if (c_flat !== exp_c) begin n_bad++; $display("FAIL postreset_c_flat got %h want %h", c_flat, exp_c); end
    endtask

    task automatic test_back_to_back();
        logic [71:0] a1;
        logic [71:0] b1;
        logic [71:0] a2;
        logic [71:0] b2;
        logic [71:0] ca;
        int m;
        a1 = rand72(); b1 = rand72();
        a2 = rand72(); b2 = rand72();
        launch(a1, b1);
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            m  = (n < 12) ? n : n - 12;
            ca = (n < 12) ? a1 : a2;
            n_cmp += 4;
            if (done !== (n == 11 || n == 23)) begin n_bad++; $display("FAIL b2b_done n=%0d got %b", n, done); end
            if (busy !== (m <= 10)) begin n_bad++; $display("FAIL b2b_busy n=%0d got %b", n, busy); end
            if (mac_start !== (m >= 1 && m <= 9)) begin n_bad++; $display("FAIL b2b_mac_start n=%0d got %b", n, mac_start); end
            if (mac_row !== ((m <= 8) ? exp_row(ca, m) : 24'h0)) begin n_bad++; $display("FAIL b2b_mac_row n=%0d got %h", n, mac_row); end
            if (n == 10) begin a_flat = a2; b_flat = b2; end
            if (n == 11) begin
                n_cmp++;
                if (c_flat !== ref_matmul(a1, b1)) begin n_bad++; $display("FAIL b2b_c1 got %h want %h", c_flat, ref_matmul(a1, b1)); end
            end
            if (n == 12) begin
                start = 1'b0;
                n_cmp++;
                if (c_flat !== 144'h0) begin n_bad++; $display("FAIL b2b_c_clear got %h want 0", c_flat); end
            end
        end
        n_cmp++;
        if (c_flat !== ref_matmul(a2, b2)) begin n_bad++; $display("FAIL b2b_c2 got %h want %h", c_flat, ref_matmul(a2, b2)); end
    endtask

    initial begin
        #2 reset = 1'b0;
        test_reset();
        test_runs();
        test_start_while_busy();
        test_reset_midrun();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
